// File: rtl/btn_debounce_repeat.sv
// Per-button 2-FF sync, debounce and auto-repeat; edges accepted DEBOUNCE_CYC+2 cycles after a stable input change.
// Outputs are registered single-cycle pulses plus a level; there is no backpressure and channels are fully independent.
module btn_debounce_repeat #(
    parameter int N_BTN        = 3,
    parameter int DEBOUNCE_CYC = 750_000,
    parameter int REPEAT_DLY   = 37_500_000,
    parameter int REPEAT_PER   = 7_500_000,
    parameter int REPEAT_EN    = 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] db_level,
    output logic [N_BTN-1:0] db_tick,
    output logic [N_BTN-1:0] db_release,
    output logic [N_BTN-1:0] rpt_tick
);

    localparam int CNT_MAX = (DEBOUNCE_CYC > REPEAT_DLY) ? DEBOUNCE_CYC : REPEAT_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(REPEAT_DLY - REPEAT_PER);
    localparam logic          RPT_ON      = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT1   = 2'd1,
        PRESSED = 2'd2,
        WAIT0   = 2'd3
    } state_t;

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_t        st;
        logic [CW-1:0] dcnt;
        logic [CW-1:0] hcnt;
        logic          lvl_q;
        logic          tick_q;
        logic          rel_q;
        logic          rpt_q;
        logic          hold_wrap;
        logic [CW-1:0] hcnt_next;

        // One held cycle: reloading (rather than clearing) keeps the repeat cadence exact.
        assign hold_wrap = (hcnt == HOLD_LAST);
        assign hcnt_next = hold_wrap ? HOLD_RELOAD : hcnt + CW'(1);

        always_ff @(posedge pclk or negedge rst) begin
            if (!rst) begin
                st     <= IDLE;
                dcnt   <= '0;
                hcnt   <= '0;
                lvl_q  <= 1'b0;
                tick_q <= 1'b0;
                rel_q  <= 1'b0;
                rpt_q  <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                rel_q  <= 1'b0;
                rpt_q  <= 1'b0;
                case (st)
                    IDLE: begin
                        lvl_q <= 1'b0;
                        if (s2[i]) begin
                            st   <= WAIT1;
                            dcnt <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!s2[i]) begin
                            st <= IDLE;
                        end else if (dcnt == DB_LAST) begin
                            st     <= PRESSED;
                            lvl_q  <= 1'b1;
                            tick_q <= 1'b1;
                            rpt_q  <= 1'b1;
                            hcnt   <= '0;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s2[i]) begin
                            st   <= WAIT0;
                            dcnt <= '0;
                        end else begin
                            hcnt  <= hcnt_next;
                            rpt_q <= hold_wrap & RPT_ON;
                        end
                    end
                    WAIT0: begin
                        // A short release glitch only freezes the hold count; the resume cycle counts as held.
                        if (s2[i]) begin
                            st    <= PRESSED;
                            hcnt  <= hcnt_next;
                            rpt_q <= hold_wrap & RPT_ON;
                        end else if (dcnt == DB_LAST) begin
                            st    <= IDLE;
                            lvl_q <= 1'b0;
                            rel_q <= 1'b1;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end

        assign db_level[i]   = lvl_q;
        assign db_tick[i]    = tick_q;
        assign db_release[i] = rel_q;
        assign rpt_tick[i]   = rpt_q;
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Scoreboarded bench for btn_debounce_repeat: behavioural run-length/hold-count model plus directed timing checks.
module tb_btn_debounce_repeat;
    localparam int NB  = 3;
    localparam int DB  = 8;
    localparam int DLY = 40;
    localparam int PER = 10;

    logic          pclk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] a_lvl, a_tick, a_rel, a_rpt;
    logic [NB-1:0] b_lvl, b_tick, b_rel, b_rpt;

    btn_debounce_repeat #(.N_BTN(NB), .DEBOUNCE_CYC(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(1)) dut (
        .pclk(pclk), .rst(rst), .btn_in(btn_in),
        .db_level(a_lvl), .db_tick(a_tick), .db_release(a_rel), .rpt_tick(a_rpt));

    btn_debounce_repeat #(.N_BTN(NB), .DEBOUNCE_CYC(DB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_EN(0)) dut_norpt (
        .pclk(pclk), .rst(rst), .btn_in(btn_in),
        .db_level(b_lvl), .db_tick(b_tick), .db_release(b_rel), .rpt_tick(b_rpt));

    always #5 pclk = ~pclk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] tick;
        logic [NB-1:0] rel;
        logic [NB-1:0] rpt;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    // Reference model: the debounced level flips once DB+1 consecutive
    // synchronized samples disagree with it; hold = count of held samples
    // since the accepted press, repeats when hold = DLY + n*PER.
    logic [NB-1:0] pipe0, pipe1, m_lvl, cur_tick, cur_rel, cur_rpt;
    int            m_run[NB];
    int            m_hold[NB];

    // Observations of the DUT used by the directed checks.
    int tick_cnt[NB], rel_cnt[NB], rpt_cnt[NB];
    int tick_last[NB], rel_last[NB], rpt_last[NB];
    bit saw_all;

    task automatic model_clear();
        pipe0 = '0; pipe1 = '0; m_lvl = '0;
        cur_tick = '0; cur_rel = '0; cur_rpt = '0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
        q.delete();
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NB; c++) begin
            tick_cnt[c] = 0; rel_cnt[c] = 0; rpt_cnt[c] = 0;
            tick_last[c] = -1; rel_last[c] = -1; rpt_last[c] = -1;
        end
        saw_all = 1'b0;
    endtask

    always @(negedge rst) model_clear();

    always @(posedge pclk) begin : model_p
        logic [NB-1:0] seen, t, r, p;
        cyc++;
        if (!rst) begin
            model_clear();
        end else begin
            seen  = pipe1;
            pipe1 = pipe0;
            pipe0 = btn_in;
            t = '0; r = '0; p = '0;
            for (int c = 0; c < NB; c++) begin
                if (seen[c] != m_lvl[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_lvl[c] && seen[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] >= DLY && (m_hold[c] - DLY) % PER == 0) p[c] = 1'b1;
                end
                if (m_run[c] == DB + 1) begin
                    m_run[c] = 0;
                    m_lvl[c] = !m_lvl[c];
                    if (m_lvl[c]) begin
                        t[c] = 1'b1;
                        p[c] = 1'b1;
                        m_hold[c] = 0;
                    end else begin
                        r[c] = 1'b1;
                    end
                end
            end
            cur_tick = t; cur_rel = r; cur_rpt = p;
            if ((t | r | p) != '0) q.push_back('{cyc, t, r, p});
        end
    end

    always @(negedge pclk) begin : monitor_p
        ev_t e;
        total++;
        if (a_lvl !== m_lvl) begin
            bad++;
            $display("FAIL level cyc=%0d got=%b want=%b", cyc, a_lvl, m_lvl);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_pulse cyc=%0d got=none want tick=%b rel=%b rpt=%b", e.cyc, e.tick, e.rel, e.rpt);
        end
        if ((a_tick | a_rel | a_rpt) != '0) begin
            total++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d got tick=%b rel=%b rpt=%b want=none", cyc, a_tick, a_rel, a_rpt);
            end else begin
                e = q.pop_front();
                if ({a_tick, a_rel, a_rpt} !== {e.tick, e.rel, e.rpt}) begin
                    bad++;
                    $display("FAIL pulse_value cyc=%0d got tick=%b rel=%b rpt=%b want tick=%b rel=%b rpt=%b",
                             cyc, a_tick, a_rel, a_rpt, e.tick, e.rel, e.rpt);
                end
            end
            for (int c = 0; c < NB; c++) begin
                if (a_tick[c]) begin tick_cnt[c]++; tick_last[c] = cyc; end
                if (a_rel[c])  begin rel_cnt[c]++;  rel_last[c]  = cyc; end
                if (a_rpt[c])  begin rpt_cnt[c]++;  rpt_last[c]  = cyc; end
            end
            if (a_tick == '1) saw_all = 1'b1;
        end
        total++;
        if ({b_lvl, b_tick, b_rel, b_rpt} !== {m_lvl, cur_tick, cur_rel, cur_tick}) begin
            bad++;
            $display("FAIL norepeat_inst cyc=%0d got lvl=%b tick=%b rel=%b rpt=%b want lvl=%b tick=%b rel=%b rpt=%b",
                     cyc, b_lvl, b_tick, b_rel, b_rpt, m_lvl, cur_tick, cur_rel, cur_tick);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge pclk);
            #2;
        end
    endtask

    initial begin : stim
        int k, a, f;
        int dur[NB];
        rst = 1'b0;
        btn_in = '0;
        clear_obs();
        #1;
        chk("reset_outputs", int'({a_lvl, a_tick, a_rel, a_rpt}), 0);
        cyc_wait(3);
        rst = 1'b1;

        // clean press on bit0 sampled at edge 100
        while (cyc < 99) cyc_wait(1);
        clear_obs();
        btn_in[0] = 1'b1;
        k = cyc + 1;
        cyc_wait(20);
        chk("t1_tick_cycle", tick_last[0], k + DB + 2);
        chk("t1_tick_count", tick_cnt[0], 1);
        chk("t1_rpt_count", rpt_cnt[0], 1);
        chk("t1_other_bits", tick_cnt[1] + tick_cnt[2], 0);

        // 3-cycle release glitch while held: cadence shifts by 3
        a = k + DB + 2;
        btn_in[0] = 1'b0;
        cyc_wait(3);
        btn_in[0] = 1'b1;
        cyc_wait(33);
        chk("t4_first_repeat", rpt_last[0], a + DLY + 3);
        chk("t4_no_release", rel_cnt[0], 0);
        chk("t4_level_held", int'(a_lvl[0]), 1);
        cyc_wait(10);
        chk("t4_second_repeat", rpt_last[0], a + DLY + PER + 3);
        btn_in[0] = 1'b0;
        f = cyc + 1;
        cyc_wait(15);
        chk("t4_release_cycle", rel_last[0], f + DB + 2);
        chk("t4_release_count", rel_cnt[0], 1);

        // bounce on bit1: 5 high, 2 low, then 20 high
        btn_in[1] = 1'b1;
        cyc_wait(5);
        btn_in[1] = 1'b0;
        cyc_wait(2);
        btn_in[1] = 1'b1;
        k = cyc + 1;
        cyc_wait(20);
        btn_in[1] = 1'b0;
        cyc_wait(15);
        chk("t2_tick_count", tick_cnt[1], 1);
        chk("t2_tick_cycle", tick_last[1], k + DB + 2);
        chk("t2_release_count", rel_cnt[1], 1);

        // long hold on bit2
        clear_obs();
        btn_in[2] = 1'b1;
        a = cyc + 1 + DB + 2;
        cyc_wait(108);
        btn_in[2] = 1'b0;
        f = cyc + 1;
        cyc_wait(15);
        chk("t3_tick_cycle", tick_last[2], a);
        chk("t3_rpt_count", rpt_cnt[2], 7);
        chk("t3_last_repeat", rpt_last[2], a + 90);
        chk("t3_release_cycle", rel_last[2], f + DB + 2);

        // reset during PRESSED (bit1) and WAIT1 (bit0), buttons kept held
        btn_in[1] = 1'b1;
        cyc_wait(15);
        chk("t5_level_before", int'(a_lvl[1]), 1);
        btn_in[0] = 1'b1;
        cyc_wait(5);
        rst = 1'b0;
        #1;
        chk("t5_outputs_in_reset", int'({a_lvl, a_tick, a_rel, a_rpt}), 0);
        cyc_wait(3);
        rst = 1'b1;
        clear_obs();
        k = cyc + 1;
        cyc_wait(15);
        chk("t5_tick0_after_reset", tick_last[0], k + DB + 2);
        chk("t5_tick1_after_reset", tick_last[1], k + DB + 2);
        btn_in = '0;
        cyc_wait(15);

        // all three on the same edge
        clear_obs();
        btn_in = '1;
        k = cyc + 1;
        cyc_wait(15);
        chk("t6_simultaneous", int'(saw_all), 1);
        chk("t6_tick2_cycle", tick_last[2], k + DB + 2);
        btn_in = '0;
        cyc_wait(15);

        // randomized bouncing and holding with rare resets
        for (int c = 0; c < NB; c++) dur[c] = 1;
        repeat (4000) begin
            for (int c = 0; c < NB; c++) begin
                dur[c]--;
                if (dur[c] == 0) begin
                    btn_in[c] = !btn_in[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 90)) : int'($urandom_range(1, 12));
                end
            end
            rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            cyc_wait(1);
        end
        rst = 1'b1;
        btn_in = '0;
        cyc_wait(30);
        chk("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
